shading_pipe: RTL and testbench

- Parametrised successor to the fixed-colour Lambert shader. Converts per-pixel (hit, surface normal, light vector) into a packed RGB pixel.
- Sits between the ray-march/normal-estimation stage and the framebuffer writer.
- Adds over the previous generation:
  - runtime-programmable material colours and a miss/background colour;
  - saturating per-channel quantisation to CHAN_BITS;
  - full valid/ready backpressure;
  - a safe drain-then-commit colour update.

---
 rtl/shading_pipe_pkg.sv | 55 +++++
 rtl/shading_pipe_shade_channel.sv | 78 +++++++
 rtl/shading_pipe.sv | 185 ++++++++++++++++++
 tb/tb_shading_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shading_pipe_pkg.sv
// ----------------------------------------------------------------------------
// shading_pipe_pkg
// Shared types and constants for the shading pipeline.
//   fp_t / vec3_t   : Q8.24 fixed-point scalar and {x,y,z} vector (x in MSBs)
//                     at the default word width.
//   FP_HALF, FP_ONE : 0.5 and 1.0 in Q8.24.
//   DEF_*           : reset values of the material colour registers, Q8.24.
//   cfg_addr_e      : colour register map used by the cfg_* write port.
//   rescale_q824()  : moves a Q8.24 constant to another fractional width so
//                     the defaults follow FRAC_BITS.
// ----------------------------------------------------------------------------
package shading_pipe_pkg;

    localparam int FP_W    = 32;
    localparam int FP_FRAC = 24;

    typedef logic signed [FP_W-1:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    localparam fp_t FP_HALF = 32'sh0080_0000;
    localparam fp_t FP_ONE  = 32'sh0100_0000;

    localparam fp_t DEF_AMB_R  = 32'sh0033_3333;  // 0.2
    localparam fp_t DEF_AMB_G  = 32'sh004C_CCCD;  // 0.3
    localparam fp_t DEF_AMB_B  = 32'sh0066_6666;  // 0.4
    localparam fp_t DEF_DIFF_R = 32'sh00CC_CCCD;  // 0.8
    localparam fp_t DEF_DIFF_G = 32'sh00B3_3333;  // 0.7
    localparam fp_t DEF_DIFF_B = 32'sh0099_999A;  // 0.6

    typedef enum logic [2:0] {
        CFG_AMB_R  = 3'd0,
        CFG_AMB_G  = 3'd1,
        CFG_AMB_B  = 3'd2,
        CFG_DIFF_R = 3'd3,
        CFG_DIFF_G = 3'd4,
        CFG_DIFF_B = 3'd5,
        CFG_BG     = 3'd6,
        CFG_NONE   = 3'd7
    } cfg_addr_e;

    function automatic logic signed [63:0] rescale_q824(input fp_t v, input int frac_bits);
        logic signed [63:0] wide;
        wide = 64'(v);
        if (frac_bits >= FP_FRAC)
            return wide <<< (frac_bits - FP_FRAC);
        else
            return wide >>> (FP_FRAC - frac_bits);
    endfunction

endpackage

// File: rtl/shading_pipe_shade_channel.sv
// ----------------------------------------------------------------------------
// shading_pipe_shade_channel
// One colour channel of the shader: stage 3 multiply-add followed by the
// stage 4 saturate/quantise register.
//   clk, rst      : clock, synchronous active-high reset
//   i_en          : pipeline advance; both stages hold when low
//   i_amb, i_diff : ambient and diffuse weights from stage 2
//   i_amb_coef    : active ambient colour coefficient of this channel
//   i_diff_coef   : active diffuse colour coefficient of this channel
//   i_s3_hit      : hit flag of the pixel currently in stage 3
//   i_bg          : background colour of this channel (used for misses)
//   o_chan        : quantised channel value, CHAN_BITS wide
// ----------------------------------------------------------------------------
module shading_pipe_shade_channel #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 24,
    parameter int CHAN_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_amb,
    input  logic signed [DATA_WIDTH-1:0] i_diff,
    input  logic signed [DATA_WIDTH-1:0] i_amb_coef,
    input  logic signed [DATA_WIDTH-1:0] i_diff_coef,
    input  logic                         i_s3_hit,
    input  logic        [CHAN_BITS-1:0]  i_bg,
    output logic        [CHAN_BITS-1:0]  o_chan
);

    typedef logic signed [DATA_WIDTH-1:0]   word_t;
    typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
    // One guard bit so the sum of two in-range products cannot wrap.
    typedef logic signed [DATA_WIDTH:0]     sum_t;

    localparam sum_t SUM_ONE = sum_t'(1) <<< FRAC_BITS;

    function automatic word_t fp_mul(input word_t a, input word_t b);
        prod_t p;
        p = prod_t'(a) * prod_t'(b);
        return word_t'(p >>> FRAC_BITS);
    endfunction

    sum_t                 w_sum;
    sum_t                 r_sum;
    logic [CHAN_BITS-1:0] w_quant;
    logic [CHAN_BITS-1:0] r_chan;

    assign w_sum = sum_t'(fp_mul(i_amb, i_amb_coef)) + sum_t'(fp_mul(i_diff, i_diff_coef));

    // NOTE: pure datapath register; its contents are meaningless until the
    // matching valid bit is set, so it carries no reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_en)
            r_sum <= w_sum;
    end

    always_comb begin
        // NOTE: default first, so no path leaves w_quant unassigned (no latch).
        w_quant = '0;
        if (r_sum >= SUM_ONE)
            w_quant = '1;
        else if (!r_sum[DATA_WIDTH])
            w_quant = r_sum[FRAC_BITS-1 -: CHAN_BITS];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_chan <= '0;
        else if (i_en)
            r_chan <= i_s3_hit ? w_quant : i_bg;
    end

    assign o_chan = r_chan;

endmodule

// File: rtl/shading_pipe.sv
// ----------------------------------------------------------------------------
// shading_pipe
// Four-stage Lambert shader with programmable colours and valid/ready flow.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake (in_ready low while a colour
//                            commit is pending)
//   in_hit                 : 1 = surface hit, 0 = background pixel
//   normal_vec, light_vec  : {x,y,z} fixed-point vectors, x in the MSBs
//   cfg_we/addr/wdata      : write one shadow colour register
//   cfg_commit, cfg_busy   : request/pending copy of shadow -> active colours
//   out_valid/out_ready    : output handshake
//   shade_out, out_hit     : {R,G,B} pixel and its hit flag
// Stages: S1 dot product, S2 ambient/diffuse weights, S3 colour multiply-add,
// S4 saturate/quantise. All stages move together on advance.
// ----------------------------------------------------------------------------
module shading_pipe
    import shading_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 24,
    parameter int CHAN_BITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_hit,
    input  logic [3*DATA_WIDTH-1:0] normal_vec,
    input  logic [3*DATA_WIDTH-1:0] light_vec,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_addr,
    input  logic [DATA_WIDTH-1:0]   cfg_wdata,
    input  logic                    cfg_commit,
    output logic                    cfg_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*CHAN_BITS-1:0]  shade_out,
    output logic                    out_hit
);

    typedef logic signed [DATA_WIDTH-1:0]     word_t;
    typedef logic signed [2*DATA_WIDTH-1:0]   prod_t;
    // Room for three full products summed without overflow.
    typedef logic signed [2*DATA_WIDTH+1:0]   dot_t;

    localparam word_t HALF = word_t'(rescale_q824(FP_HALF, FRAC_BITS));

    localparam word_t COLOUR_DEF [6] = '{
        word_t'(rescale_q824(DEF_AMB_R,  FRAC_BITS)),
        word_t'(rescale_q824(DEF_AMB_G,  FRAC_BITS)),
        word_t'(rescale_q824(DEF_AMB_B,  FRAC_BITS)),
        word_t'(rescale_q824(DEF_DIFF_R, FRAC_BITS)),
        word_t'(rescale_q824(DEF_DIFF_G, FRAC_BITS)),
        word_t'(rescale_q824(DEF_DIFF_B, FRAC_BITS))
    };

    function automatic word_t fp_mul(input word_t a, input word_t b);
        prod_t p;
        p = prod_t'(a) * prod_t'(b);
        return word_t'(p >>> FRAC_BITS);
    endfunction

    // ---------------- handshake and colour commit ----------------
    logic w_advance, w_accept, w_empty;
    logic r_busy;
    logic r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic r_s1_hit,   r_s2_hit,   r_s3_hit,   r_s4_hit;

    word_t                r_shadow [6];
    word_t                r_active [6];
    logic [3*CHAN_BITS-1:0] r_shadow_bg;
    logic [3*CHAN_BITS-1:0] r_active_bg;

    assign w_advance = !r_s4_valid || out_ready;
    assign in_ready  = w_advance && !r_busy;
    assign w_accept  = in_valid && in_ready;
    assign w_empty   = !(r_s1_valid || r_s2_valid || r_s3_valid || r_s4_valid);

    // Colours switch only when the pipeline is empty, so every pixel in
    // flight is shaded with a single colour set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= COLOUR_DEF;
            r_active    <= COLOUR_DEF;
            r_shadow_bg <= '0;
            r_active_bg <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr_e'(cfg_addr))
                    CFG_BG:   r_shadow_bg <= cfg_wdata[3*CHAN_BITS-1:0];
                    CFG_NONE: ;
                    default:  r_shadow[cfg_addr] <= word_t'(cfg_wdata);
                endcase
            end
            // A commit arriving while one is pending is simply absorbed.
            if (r_busy && w_empty) begin
                r_active    <= r_shadow;
                r_active_bg <= r_shadow_bg;
                r_busy      <= 1'b0;
            end else if (cfg_commit) begin
                r_busy <= 1'b1;
            end
        end
    end

    // ---------------- control pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid} <= '0;
            {r_s1_hit,   r_s2_hit,   r_s3_hit,   r_s4_hit}   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s4_valid <= r_s3_valid;
            r_s1_hit   <= in_hit;
            r_s2_hit   <= r_s1_hit;
            r_s3_hit   <= r_s2_hit;
            r_s4_hit   <= r_s3_hit;
        end
    end

    // ---------------- S1: dot product and ambient term ----------------
    word_t w_n_x, w_n_y, w_n_z, w_l_x, w_l_y, w_l_z;
    dot_t  w_dot_full;
    word_t w_dot, w_ambc;
    word_t r_s1_dot, r_s1_ambc;

    assign w_n_x = word_t'(normal_vec[3*DATA_WIDTH-1 -: DATA_WIDTH]);
    assign w_n_y = word_t'(normal_vec[2*DATA_WIDTH-1 -: DATA_WIDTH]);
    assign w_n_z = word_t'(normal_vec[DATA_WIDTH-1:0]);
    assign w_l_x = word_t'(light_vec[3*DATA_WIDTH-1 -: DATA_WIDTH]);
    assign w_l_y = word_t'(light_vec[2*DATA_WIDTH-1 -: DATA_WIDTH]);
    assign w_l_z = word_t'(light_vec[DATA_WIDTH-1:0]);

    // Full-precision sum of products, truncated once at the end.
    assign w_dot_full = dot_t'(w_n_x) * dot_t'(w_l_x)
                      + dot_t'(w_n_y) * dot_t'(w_l_y)
                      + dot_t'(w_n_z) * dot_t'(w_l_z);
    assign w_dot  = word_t'(w_dot_full >>> FRAC_BITS);
    assign w_ambc = w_n_y[DATA_WIDTH-1] ? '0 : w_n_y;

    // ---------------- S2: diffuse and ambient weights ----------------
    word_t w_diff, w_amb;
    word_t r_s2_diff, r_s2_amb;

    assign w_diff = r_s1_dot[DATA_WIDTH-1] ? '0 : r_s1_dot;
    assign w_amb  = HALF + fp_mul(HALF, r_s1_ambc);

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_dot  <= w_dot;
            r_s1_ambc <= w_ambc;
            r_s2_diff <= w_diff;
            r_s2_amb  <= w_amb;
        end
    end

    // ---------------- S3/S4: per-channel colour ----------------
    // Channel 0 is red and lands in the top CHAN_BITS of shade_out.
    for (genvar c = 0; c < 3; c++) begin : g_chan
        shading_pipe_shade_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .CHAN_BITS  (CHAN_BITS)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_en        (w_advance),
            .i_amb       (r_s2_amb),
            .i_diff      (r_s2_diff),
            .i_amb_coef  (r_active[int'(CFG_AMB_R) + c]),
            .i_diff_coef (r_active[int'(CFG_DIFF_R) + c]),
            .i_s3_hit    (r_s3_hit),
            .i_bg        (r_active_bg[(2-c)*CHAN_BITS +: CHAN_BITS]),
            .o_chan      (shade_out[(2-c)*CHAN_BITS +: CHAN_BITS])
        );
    end

    assign out_valid = r_s4_valid;
    assign out_hit   = r_s4_hit;
    assign cfg_busy  = r_busy;

endmodule

// File: tb/tb_shading_pipe.sv
// ----------------------------------------------------------------------------
// tb_shading_pipe
// Directed bench for shading_pipe at default parameters (Q8.24, 8-bit
// channels). Inputs are driven on the falling edge and outputs sampled 1 ns
// later, well away from the rising edge. Expected pixels are hand-computed
// from the default colours.
// ----------------------------------------------------------------------------
module tb_shading_pipe;

    localparam logic [31:0] P1 = 32'h0100_0000;  //  1.0
    localparam logic [31:0] M1 = 32'hFF00_0000;  // -1.0
    localparam logic [31:0] PH = 32'h0080_0000;  //  0.5
    localparam logic [31:0] Z  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_hit;
    logic [95:0] normal_vec;
    logic [95:0] light_vec;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_commit;
    logic        cfg_busy;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] shade_out;
    logic        out_hit;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    shading_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_hit     (in_hit),
        .normal_vec (normal_vec),
        .light_vec  (light_vec),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .shade_out  (shade_out),
        .out_hit    (out_hit)
    );

    function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return {x, y, z};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts just after a falling edge. Sends one pixel into an empty pipe
    // and checks it appears exactly four rising edges later.
    task automatic send_one(input string tag, input logic [95:0] n, input logic [95:0] l,
                            input logic hit, input logic [23:0] exp_shade);
        in_valid   = 1'b1;
        normal_vec = n;
        light_vec  = l;
        in_hit     = hit;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_not_early"}, out_valid, 0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_shade"}, shade_out, exp_shade);
        check({tag, "_hit"}, out_hit, hit);
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    logic [95:0] sn [6];
    logic [95:0] sl [6];
    logic        sh [6];
    logic [23:0] se [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int in_idx, out_idx, sent, got, busy_n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_hit     = 1'b0;
        normal_vec = '0;
        light_vec  = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_commit = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_shade", shade_out, 0);
        check("rst_out_hit", out_hit, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Default colours, several geometries
        send_one("sat_up",   v3(Z, P1, Z), v3(Z, P1, Z), 1'b1, 24'hFFFFFF);
        send_one("back",     v3(Z, M1, Z), v3(Z, P1, Z), 1'b1, 24'h192633);
        send_one("side_x",   v3(P1, Z, Z), v3(P1, Z, Z), 1'b1, 24'hE6D9CC);
        send_one("half_lit", v3(Z, P1, Z), v3(Z, PH, Z), 1'b1, 24'h99A6B3);
        send_one("amb_only", v3(Z, P1, Z), v3(Z, M1, Z), 1'b1, 24'h334C66);

        // Shadow BG write alone must not change the active background
        cfg_write(3'd6, 32'h0010_2030);
        send_one("bg_old", v3(Z, P1, Z), v3(Z, P1, Z), 1'b0, 24'h000000);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        #1;
        check("commit_busy", cfg_busy, 1);
        check("commit_blocks", in_ready, 0);
        @(negedge clk);
        #1;
        check("commit_done", cfg_busy, 0);
        @(negedge clk);
        send_one("bg_new", v3(Z, P1, Z), v3(Z, P1, Z), 1'b0, 24'h102030);

        // Stream of 6 pixels with out_ready low for the first 10 cycles
        sn[0] = v3(Z, P1, Z);  sl[0] = v3(Z, P1, Z);  sh[0] = 1'b1; se[0] = 24'hFFFFFF;
        sn[1] = v3(Z, M1, Z);  sl[1] = v3(Z, P1, Z);  sh[1] = 1'b1; se[1] = 24'h192633;
        sn[2] = v3(P1, Z, Z);  sl[2] = v3(P1, Z, Z);  sh[2] = 1'b1; se[2] = 24'hE6D9CC;
        sn[3] = v3(Z, P1, Z);  sl[3] = v3(Z, PH, Z);  sh[3] = 1'b1; se[3] = 24'h99A6B3;
        sn[4] = v3(Z, P1, Z);  sl[4] = v3(Z, P1, Z);  sh[4] = 1'b0; se[4] = 24'h102030;
        sn[5] = v3(Z, P1, Z);  sl[5] = v3(Z, M1, Z);  sh[5] = 1'b1; se[5] = 24'h334C66;
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
            out_ready = (cyc >= 10);
            in_valid  = (in_idx < 6);
            if (in_idx < 6) begin
                normal_vec = sn[in_idx];
                light_vec  = sl[in_idx];
                in_hit     = sh[in_idx];
            end
            #1;
            if (out_valid) begin
                check($sformatf("stream_shade%0d", out_idx), shade_out, se[out_idx]);
                check($sformatf("stream_hit%0d", out_idx), out_hit, sh[out_idx]);
                if (out_ready)
                    out_idx++;
            end
            if (cyc == 9) begin
                check("stream_accepted_while_stalled", in_idx, 4);
                check("stream_in_ready_low", in_ready, 0);
            end
            if (in_valid && in_ready)
                in_idx++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", out_idx, 6);

        // New AMB_R = -1.0 sits in shadow only until commit
        cfg_write(3'd0, M1);
        send_one("shadow_only", v3(Z, M1, Z), v3(Z, P1, Z), 1'b1, 24'h192633);

        // Commit with 3 pixels in flight; 4th pixel waits for the new colours
        sent       = 0;
        got        = 0;
        busy_n     = 0;
        normal_vec = v3(Z, M1, Z);
        light_vec  = v3(Z, P1, Z);
        in_hit     = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid   = (sent < 4);
            cfg_commit = (cyc == 2);
            #1;
            if (cfg_busy) begin
                busy_n++;
                check("busy_blocks_input", in_ready, 0);
            end
            if (out_valid) begin
                check($sformatf("commit_px%0d", got), shade_out,
                      (got < 3) ? 24'h192633 : 24'h002633);
                got++;
            end
            if (in_valid && in_ready)
                sent++;
            @(negedge clk);
        end
        cfg_commit = 1'b0;
        in_valid   = 1'b0;
        check("commit_px_count", got, 4);
        check("commit_busy_cycles", busy_n, 5);
        @(negedge clk);

        // Shadow write in the same cycle as commit lands before the copy
        cfg_we     = 1'b1;
        cfg_addr   = 3'd6;
        cfg_wdata  = 32'h0000_00AA;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        #1;
        check("we_commit_busy", cfg_busy, 1);
        @(negedge clk);
        #1;
        check("we_commit_done", cfg_busy, 0);
        @(negedge clk);
        send_one("we_commit_bg", v3(Z, P1, Z), v3(Z, P1, Z), 1'b0, 24'h0000AA);

        // Reset with a full, stalled pipeline and a pending commit
        cfg_write(3'd1, Z);
        out_ready  = 1'b0;
        normal_vec = v3(Z, P1, Z);
        light_vec  = v3(Z, P1, Z);
        in_hit     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid   = 1'b1;
            cfg_commit = (k == 4);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        cfg_commit = 1'b0;
        #1;
        check("pre_rst_busy", cfg_busy, 1);
        check("pre_rst_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_shade", shade_out, 0);
        check("mid_rst_hit", out_hit, 0);
        check("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        send_one("post_rst_active", v3(Z, M1, Z), v3(Z, P1, Z), 1'b1, 24'h192633);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("post_rst_commit_done", cfg_busy, 0);
        @(negedge clk);
        send_one("post_rst_shadow", v3(Z, M1, Z), v3(Z, P1, Z), 1'b1, 24'h192633);
        send_one("post_rst_bg", v3(Z, P1, Z), v3(Z, P1, Z), 1'b0, 24'h000000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
